clk_enable_monitor: RTL

Receiving end of the clk_divider enable interface: samples clk_enable / clk_enable_n and turns them into single-cycle rise/fall strobes for downstream pipeline-stage logic. It also tracks divider phase and counts completed enable periods. It checks the enable pair is complementary with the programmed high/low run lengths, and raises a sticky fault on violation. Sits beside clk_divider at the processor top level; the processor's stage controller consumes its strobes and locked flag.

---
 rtl/clk_enable_monitor_pkg.sv | 20 ++
 rtl/clk_enable_monitor_if.sv | 32 +++
 rtl/clk_enable_monitor_edge_detect.sv | 48 ++++
 rtl/clk_enable_monitor.sv | 127 ++++++++++++
 4 files changed

// File: rtl/clk_enable_monitor_pkg.sv
// Shared types for the clk_enable monitor.
//   state_t      : monitor FSM state (IDLE -> SYNC -> LOCKED, FAULT is sticky)
//   fault_code_t : reason reported while in FAULT
package clk_enable_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,  // no fault
        FC_RUN   = 2'd1,  // completed run was not HALF_PERIOD long
        FC_COMPL = 2'd2,  // clk_enable == clk_enable_n at a sample
        FC_STUCK = 2'd3   // run reached HALF_PERIOD without an edge
    } fault_code_t;

endpackage

// File: rtl/clk_enable_monitor_if.sv
// Bus between the clk_divider enable pair / stage controller and the monitor.
//   master : drives clk_enable, clk_enable_n, clear_fault; reads status
//   slave  : the monitor; reads the enable pair, drives strobes and status
interface clk_enable_monitor_if
    import clk_enable_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PER_W = 16
);
    logic             clk_enable;
    logic             clk_enable_n;
    logic             clear_fault;
    logic             rise_strobe;
    logic             fall_strobe;
    logic             locked;
    logic             fault;
    fault_code_t      fault_code;
    logic [CNT_W-1:0] phase_cnt;
    logic [PER_W-1:0] period_cnt;

    modport master (
        output clk_enable, clk_enable_n, clear_fault,
        input  rise_strobe, fall_strobe, locked, fault, fault_code,
               phase_cnt, period_cnt
    );

    modport slave (
        input  clk_enable, clk_enable_n, clear_fault,
        output rise_strobe, fall_strobe, locked, fault, fault_code,
               phase_cnt, period_cnt
    );
endinterface

// File: rtl/clk_enable_monitor_edge_detect.sv
// Edge detector and run-length counter for the sampled enable.
//   clk, reset   : clock, async active-high reset
//   en_i         : clk_enable as sampled this cycle
//   clr_run_i    : force run length to 0 (used when leaving FAULT)
//   rise_o/fall_o/edge_o : combinational edge flags versus the previous sample
//   run_len_o    : length of the run in progress before this sample
//                  (equals the completed run length when edge_o is high)
module enable_edge_detect #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_run_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic             edge_o,
    output logic [CNT_W-1:0] run_len_o
);
    logic             en_q;
    logic [CNT_W-1:0] run_q, run_d;

    assign rise_o    = en_i & ~en_q;
    assign fall_o    = ~en_i & en_q;
    assign edge_o    = en_i ^ en_q;
    assign run_len_o = run_q;

    always_comb begin
        run_d = run_q;
        if (clr_run_i)
            run_d = '0;
        else if (edge_o)
            run_d = CNT_W'(1);
        else if (run_q != '1)
            run_d = run_q + CNT_W'(1);
    end

    // en_q keeps tracking through every state, including the clear cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q  <= 1'b0;
            run_q <= '0;
        end else begin
            en_q  <= en_i;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/clk_enable_monitor.sv
// clk_enable monitor: turns the divider's enable pair into rise/fall strobes,
// tracks phase and completed periods, and latches a sticky fault when the
// pair stops matching the programmed HALF_PERIOD cadence.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of clk_enable_monitor_if
//                in : clk_enable, clk_enable_n, clear_fault
//                out: rise_strobe, fall_strobe, locked, fault, fault_code,
//                     phase_cnt, period_cnt (all registered)
module clk_enable_monitor
    import clk_enable_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int LOCK_COUNT  = 2,
    parameter int CNT_W       = 8,
    parameter int PER_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    clk_enable_monitor_if.slave  bus
);
    localparam int              GW        = $clog2(2*LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] HP        = CNT_W'(HALF_PERIOD);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(2*LOCK_COUNT - 1);

    state_t           state_q;
    logic [GW-1:0]    good_q;
    logic             rise_q, fall_q, locked_q, fault_q;
    fault_code_t      code_q;
    logic [CNT_W-1:0] phase_q;
    logic [PER_W-1:0] period_q;

    logic             rise, fall, is_edge;
    logic [CNT_W-1:0] run_len;
    logic             compl_err, good_run, clr_run;

    assign compl_err = (bus.clk_enable == bus.clk_enable_n);
    // On an edge this is the completed run; without an edge, a run that has
    // already reached HALF_PERIOD is about to overrun.
    assign good_run  = (run_len == HP);
    assign clr_run   = (state_q == FAULT) && bus.clear_fault;

    enable_edge_detect #(.CNT_W(CNT_W)) u_edge (
        .clk       (clk),
        .reset     (reset),
        .en_i      (bus.clk_enable),
        .clr_run_i (clr_run),
        .rise_o    (rise),
        .fall_o    (fall),
        .edge_o    (is_edge),
        .run_len_o (run_len)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            good_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            phase_q  <= '0;
            period_q <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (is_edge) begin
                        state_q <= SYNC;
                        good_q  <= '0;
                    end
                end
                SYNC: begin
                    if (compl_err) begin
                        good_q <= '0;
                    end else if (is_edge) begin
                        if (!good_run) begin
                            good_q <= '0;
                        end else if (good_q == GOOD_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            good_q   <= '0;
                        end else begin
                            good_q <= good_q + GW'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (compl_err || (is_edge != good_run)) begin
                        // Priority: complement > bad run at edge > stuck.
                        state_q  <= FAULT;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b1;
                        code_q   <= compl_err ? FC_COMPL :
                                    (is_edge  ? FC_RUN : FC_STUCK);
                    end else begin
                        rise_q <= rise;
                        fall_q <= fall;
                        if (rise) begin
                            phase_q  <= '0;
                            period_q <= period_q + PER_W'(1);
                        end else if (phase_q != '1) begin
                            phase_q <= phase_q + CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (bus.clear_fault) begin
                        state_q <= IDLE;
                        fault_q <= 1'b0;
                        code_q  <= FC_NONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rise_strobe = rise_q;
    assign bus.fall_strobe = fall_q;
    assign bus.locked      = locked_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.phase_cnt   = phase_q;
    assign bus.period_cnt  = period_q;
endmodule
